// File: rtl/intersection_phase_scheduler_if.sv
// rtl/intersection_phase_scheduler_if.sv - sensor inputs and lamp outputs of the intersection scheduler
// Optional EMERGENCY_PREEMPT_EN adds the emg preemption input.
interface intersection_phase_scheduler_if;
    logic       side_car;
    logic       ped_req;
`ifdef EMERGENCY_PREEMPT_EN
    logic       emg;
`endif
    logic       main_red;
    logic       main_yellow;
    logic       main_green;
    logic       side_red;
    logic       side_yellow;
    logic       side_green;
    logic       walk;
    logic [2:0] phase;

    modport slave (
        input  side_car,
        input  ped_req,
`ifdef EMERGENCY_PREEMPT_EN
        input  emg,
`endif
        output main_red,
        output main_yellow,
        output main_green,
        output side_red,
        output side_yellow,
        output side_green,
        output walk,
        output phase
    );

    modport master (
        output side_car,
        output ped_req,
`ifdef EMERGENCY_PREEMPT_EN
        output emg,
`endif
        input  main_red,
        input  main_yellow,
        input  main_green,
        input  side_red,
        input  side_yellow,
        input  side_green,
        input  walk,
        input  phase
    );
endinterface

// File: rtl/intersection_phase_scheduler.sv
// rtl/intersection_phase_scheduler.sv - two-road intersection phase FSM with pedestrian walk service
// Optional feature macro: EMERGENCY_PREEMPT_EN (emergency preemption back to main green).
module intersection_phase_scheduler #(
    parameter int MAIN_MIN_T = 8,
    parameter int SIDE_MIN_T = 4,
    parameter int SIDE_MAX_T = 10,
    parameter int YEL_T      = 3,
    parameter int AR_T       = 2,
    parameter int WALK_T     = 4,
    parameter int CNT_W      = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    intersection_phase_scheduler_if.slave   bus
);
    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_A   = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALL_RED_B   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] MAIN_LAST     = CNT_W'(MAIN_MIN_T - 1);
    localparam logic [CNT_W-1:0] SIDE_MIN_LAST = CNT_W'(SIDE_MIN_T - 1);
    localparam logic [CNT_W-1:0] SIDE_MAX_LAST = CNT_W'(SIDE_MAX_T - 1);
    localparam logic [CNT_W-1:0] YEL_LAST      = CNT_W'(YEL_T - 1);
    localparam logic [CNT_W-1:0] AR_LAST       = CNT_W'(AR_T - 1);
    localparam logic [CNT_W-1:0] WALK_LAST     = CNT_W'(WALK_T - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ped_pend, ped_pend_nxt;
    logic             walk_act, walk_act_nxt;
    logic             emg;
    logic             req;
    logic             side_entry;

`ifdef EMERGENCY_PREEMPT_EN
    assign emg = bus.emg;
`else
    assign emg = 1'b0;
`endif

    assign req = bus.side_car | ped_pend | bus.ped_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ALL_RED_B;
            cnt      <= '0;
            ped_pend <= 1'b0;
            walk_act <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ped_pend <= ped_pend_nxt;
            walk_act <= walk_act_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MAIN_GREEN:  if (cnt == MAIN_LAST && req && !emg) state_nxt = MAIN_YELLOW;
            MAIN_YELLOW: if (cnt == YEL_LAST) state_nxt = ALL_RED_A;
            ALL_RED_A:   if (cnt == AR_LAST) state_nxt = emg ? MAIN_GREEN : SIDE_GREEN;
            SIDE_GREEN:  if (emg || (cnt >= SIDE_MIN_LAST && !bus.side_car) || cnt == SIDE_MAX_LAST)
                             state_nxt = SIDE_YELLOW;
            SIDE_YELLOW: if (cnt == YEL_LAST) state_nxt = ALL_RED_B;
            ALL_RED_B:   if (cnt == AR_LAST) state_nxt = MAIN_GREEN;
            default:     state_nxt = ALL_RED_B;
        endcase

        // Counter restarts on any state change; MAIN_GREEN parks at its last value while idle.
        if (state_nxt != state)
            cnt_nxt = '0;
        else if (state == MAIN_GREEN && cnt == MAIN_LAST)
            cnt_nxt = cnt;
        else
            cnt_nxt = cnt + 1'b1;

        side_entry   = (state == ALL_RED_A) && (state_nxt == SIDE_GREEN);
        ped_pend_nxt = side_entry ? 1'b0 : (ped_pend | bus.ped_req);

        if (side_entry)
            walk_act_nxt = ped_pend | bus.ped_req;
        else if (state == SIDE_GREEN && (cnt == WALK_LAST || state_nxt != SIDE_GREEN))
            walk_act_nxt = 1'b0;
        else
            walk_act_nxt = walk_act;
    end

    always_comb begin
        bus.main_green  = (state == MAIN_GREEN);
        bus.main_yellow = (state == MAIN_YELLOW);
        bus.main_red    = !(state == MAIN_GREEN || state == MAIN_YELLOW);
        bus.side_green  = (state == SIDE_GREEN);
        bus.side_yellow = (state == SIDE_YELLOW);
        bus.side_red    = !(state == SIDE_GREEN || state == SIDE_YELLOW);
        bus.walk        = walk_act;
        bus.phase       = state;
    end
endmodule
